// File: rtl/ctrl_axi_lite_slave.sv
// ctrl_axi_lite_slave: AXI4-Lite slave that turns each host access into one ctrl-bus request
//   clock, resetn                      : rising-edge clock, asynchronous active-low reset
//   AW*/W*/B*                          : AXI4-Lite write address, write data and write response
//   AR*/R*                             : AXI4-Lite read address and read data
//   ctrlSel/ctrlWr/ctrlAddr/ctrlWrData/ctrlWrStrbs : request towards the control-interface mux
//   ctrlWrRdy/ctrlRdData/ctrlRdValid   : completion coming back from the mux
//   TIMEOUT                            : REQ cycles before SLVERR, 0 waits forever
module ctrl_axi_lite_slave #(
    parameter int TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [10:0] AWADDR,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [10:0] ARADDR,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        ctrlSel,
    output logic        ctrlWr,
    output logic [10:0] ctrlAddr,
    output logic [31:0] ctrlWrData,
    output logic [3:0]  ctrlWrStrbs,
    input  logic        ctrlWrRdy,
    input  logic [31:0] ctrlRdData,
    input  logic        ctrlRdValid
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] W_ACC = 3'd1;
    localparam logic [2:0] W_REQ = 3'd2;
    localparam logic [2:0] W_RSP = 3'd3;
    localparam logic [2:0] R_ACC = 3'd4;
    localparam logic [2:0] R_REQ = 3'd5;
    localparam logic [2:0] R_RSP = 3'd6;
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [2:0]  state;
    logic        lastWr;
    logic [15:0] waitCnt;
    logic        wrPend;
    logic        rdPend;
    logic        pickWr;
    logic        timedOut;
    logic        unusedAddrBits;

    // Byte lanes inside a word are selected by strobes, so the low address bits carry nothing
    assign unusedAddrBits = ^{AWADDR[1:0], ARADDR[1:0]};

    // On a tie the write goes first only if the previous grant was a read, so neither side starves
    always_comb begin
        wrPend   = AWVALID & WVALID;
        rdPend   = ARVALID;
        pickWr   = wrPend & (~rdPend | ~lastWr);
        timedOut = (TIMEOUT != 0) && (waitCnt == LAST_WAIT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            lastWr      <= 1'b0;
            waitCnt     <= '0;
            AWREADY     <= 1'b0;
            WREADY      <= 1'b0;
            BVALID      <= 1'b0;
            BRESP       <= OKAY;
            ARREADY     <= 1'b0;
            RVALID      <= 1'b0;
            RDATA       <= '0;
            RRESP       <= OKAY;
            ctrlSel     <= 1'b0;
            ctrlWr      <= 1'b0;
            ctrlAddr    <= '0;
            ctrlWrData  <= '0;
            ctrlWrStrbs <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickWr) begin
                        state   <= W_ACC;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end else if (rdPend) begin
                        state   <= R_ACC;
                        ARREADY <= 1'b1;
                    end
                end
                W_ACC: begin
                    AWREADY     <= 1'b0;
                    WREADY      <= 1'b0;
                    ctrlAddr    <= {AWADDR[10:2], 2'b00};
                    ctrlWrData  <= WDATA;
                    ctrlWrStrbs <= WSTRB;
                    ctrlWr      <= 1'b1;
                    ctrlSel     <= 1'b1;
                    lastWr      <= 1'b1;
                    waitCnt     <= '0;
                    state       <= W_REQ;
                end
                W_REQ: begin
                    // A ready seen in the timeout cycle still completes as OKAY
                    if (ctrlWrRdy || timedOut) begin
                        ctrlSel <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= ctrlWrRdy ? OKAY : SLVERR;
                        state   <= W_RSP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                W_RSP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                R_ACC: begin
                    ARREADY  <= 1'b0;
                    ctrlAddr <= {ARADDR[10:2], 2'b00};
                    ctrlWr   <= 1'b0;
                    ctrlSel  <= 1'b1;
                    lastWr   <= 1'b0;
                    waitCnt  <= '0;
                    state    <= R_REQ;
                end
                R_REQ: begin
                    if (ctrlRdValid || timedOut) begin
                        ctrlSel <= 1'b0;
                        RVALID  <= 1'b1;
                        RDATA   <= ctrlRdValid ? ctrlRdData : 32'h0;
                        RRESP   <= ctrlRdValid ? OKAY : SLVERR;
                        state   <= R_RSP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                R_RSP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_axi_lite_slave.sv
// tb_ctrl_axi_lite_slave: scoreboard bench with a memory-backed ctrl target and variable latency
module tb_ctrl_axi_lite_slave;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [10:0] AWADDR = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [10:0] ARADDR = '0;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        ctrlSel;
    logic        ctrlWr;
    logic [10:0] ctrlAddr;
    logic [31:0] ctrlWrData;
    logic [3:0]  ctrlWrStrbs;
    logic        ctrlWrRdy;
    logic [31:0] ctrlRdData;
    logic        ctrlRdValid;

    ctrl_axi_lite_slave #(.TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ctrlSel(ctrlSel), .ctrlWr(ctrlWr), .ctrlAddr(ctrlAddr),
        .ctrlWrData(ctrlWrData), .ctrlWrStrbs(ctrlWrStrbs),
        .ctrlWrRdy(ctrlWrRdy), .ctrlRdData(ctrlRdData), .ctrlRdValid(ctrlRdValid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Target: answers lat cycles after ctrlSel rises (lat 0 = same cycle), never if lat >= TO
    int lat = 0;
    int selCnt = 0;
    logic [31:0] tgtMem [512] = '{default: '0};
    assign ctrlWrRdy   = ctrlSel && ctrlWr && (selCnt == lat);
    assign ctrlRdValid = ctrlSel && !ctrlWr && (selCnt == lat);
    assign ctrlRdData  = tgtMem[ctrlAddr[10:2]];
    always @(posedge clock) begin
        selCnt <= ctrlSel ? selCnt + 1 : 0;
        if (ctrlWrRdy)
            for (int b = 0; b < 4; b++)
                if (ctrlWrStrbs[b]) tgtMem[ctrlAddr[10:2]][8*b +: 8] <= ctrlWrData[8*b +: 8];
    end

    // Reference model and scoreboard queues
    logic [31:0] refMem [512] = '{default: '0};
    logic [1:0]  bExpQ[$];
    logic [33:0] rExpQ[$];
    logic [46:0] ctrlWQ[$];
    logic [10:0] ctrlRQ[$];
    bit          orderQ[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic startWrite(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = lat < TO;
        bExpQ.push_back(ok ? 2'b00 : 2'b10);
        ctrlWQ.push_back({a[10:2], 2'b00, d, s});
        if (ok)
            for (int b = 0; b < 4; b++)
                if (s[b]) refMem[a[10:2]][8*b +: 8] = d[8*b +: 8];
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    endtask

    task automatic startRead(input logic [10:0] a);
        bit ok = lat < TO;
        rExpQ.push_back(ok ? {2'b00, refMem[a[10:2]]} : {2'b10, 32'h0});
        ctrlRQ.push_back({a[10:2], 2'b00});
        ARADDR = a; ARVALID = 1'b1;
    endtask

    task automatic waitAw();
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = AWREADY && WREADY;
        end
        check("aw/w handshake", got, 1);
        @(posedge clock); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic waitAr();
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = ARREADY;
        end
        check("ar handshake", got, 1);
        @(posedge clock); #1;
        ARVALID = 1'b0;
    endtask

    task automatic finishB(input int stall);
        bit got = 0;
        repeat (stall + 1) @(posedge clock);
        #1 BREADY = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = BVALID;
        end
        check("b handshake", got, 1);
        @(posedge clock); #1 BREADY = 1'b0;
    endtask

    task automatic finishR(input int stall);
        bit got = 0;
        repeat (stall + 1) @(posedge clock);
        #1 RREADY = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = RVALID;
        end
        check("r handshake", got, 1);
        @(posedge clock); #1 RREADY = 1'b0;
    endtask

    // Monitor: ctrl-bus requests, responses, stability and grant order, sampled mid-cycle
    int selRise = 0, selLen = 0, selRun = 0, bvRise = 0, rvRise = 0;
    logic selPrev = 0, bvPrev = 0, rvPrev = 0;
    logic [31:0] rdHeld = 0;
    logic [1:0]  rrHeld = 0, brHeld = 0;
    logic [10:0] addrHeld = 0;
    always @(negedge clock) begin
        if (!resetn) begin
            selPrev <= 0; bvPrev <= 0; rvPrev <= 0; selRun <= 0;
        end else begin
            if (AWREADY || ARREADY) begin
                check("ready overlap", AWREADY & ARREADY, 0);
                if (AWREADY) orderQ.push_back(1'b1);
                if (ARREADY) orderQ.push_back(1'b0);
            end
            if (ctrlSel && !selPrev) begin
                selRise <= cyc;
                if (ctrlWr) begin
                    check("ctrl write queued", ctrlWQ.size() > 0, 1);
                    if (ctrlWQ.size() > 0) begin
                        check("ctrl write req", {ctrlAddr, ctrlWrData, ctrlWrStrbs}, ctrlWQ[0]);
                        addrHeld <= ctrlWQ[0][46:36];
                        void'(ctrlWQ.pop_front());
                    end
                end else begin
                    check("ctrl read queued", ctrlRQ.size() > 0, 1);
                    if (ctrlRQ.size() > 0) begin
                        check("ctrl read addr", ctrlAddr, ctrlRQ[0]);
                        addrHeld <= ctrlRQ[0];
                        void'(ctrlRQ.pop_front());
                    end
                end
            end
            if (ctrlSel) selRun <= selRun + 1;
            else if (selPrev) begin
                selLen <= selRun;
                selRun <= 0;
            end
            if (BVALID && !bvPrev) bvRise <= cyc;
            if (BVALID && bvPrev) check("bresp stable", BRESP, brHeld);
            if (BVALID && BREADY) begin
                check("b queued", bExpQ.size() > 0, 1);
                if (bExpQ.size() > 0) check("bresp", BRESP, bExpQ.pop_front());
                check("ctrlAddr held in b phase", ctrlAddr, addrHeld);
            end
            if (RVALID && !rvPrev) rvRise <= cyc;
            if (RVALID && rvPrev) begin
                check("rdata stable", RDATA, rdHeld);
                check("rresp stable", RRESP, rrHeld);
            end
            if (RVALID && RREADY) begin
                check("r queued", rExpQ.size() > 0, 1);
                if (rExpQ.size() > 0) check("rresp/rdata", {RRESP, RDATA}, rExpQ.pop_front());
                check("ctrlAddr held in r phase", ctrlAddr, addrHeld);
            end
            selPrev <= ctrlSel; bvPrev <= BVALID; rvPrev <= RVALID;
            rdHeld <= RDATA; rrHeld <= RRESP; brHeld <= BRESP;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int t0;
        int stall;
        logic [10:0] a;
        repeat (3) @(negedge clock);
        check("in-reset handshake outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, ctrlSel, ctrlWr}, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("reset handshake outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, ctrlSel, ctrlWr, ctrlWrStrbs}, 0);
        check("reset rdata", RDATA, 0);
        check("reset ctrl addr/data", {ctrlAddr, ctrlWrData}, 0);

        // Contention right after reset: grants alternate starting with the write
        lat = 0;
        orderQ.delete();
        @(posedge clock); #1;
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    startWrite(11'h100 + 11'(4 * i), $urandom, 4'hF); waitAw(); finishB(0);
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    startRead(11'h200 + 11'(4 * j)); waitAr(); finishR(0);
                end
            end
        join
        check("grant count", orderQ.size(), 4);
        for (int i = 0; i < orderQ.size() && i < 4; i++) check("grant order", orderQ[i], (i % 2) == 0);

        // Zero-wait write timing
        @(posedge clock); #1; t0 = cyc;
        startWrite(11'h004, 32'hDEADBEEF, 4'hF); waitAw(); finishB(0);
        check("write ctrlSel cycle", selRise - t0, 2);
        check("write ctrlSel length", selLen, 1);
        check("write BVALID cycle", bvRise - t0, 3);

        // Read with target answering 3 cycles after ctrlSel
        @(posedge clock); #1;
        startWrite(11'h460, 32'h12345678, 4'hF); waitAw(); finishB(0);
        lat = 3;
        @(posedge clock); #1; t0 = cyc;
        startRead(11'h460); waitAr(); finishR(0);
        check("read ctrlSel cycle", selRise - t0, 2);
        check("read ctrlSel length", selLen, 4);
        check("read RVALID cycle", rvRise - t0, 6);

        // Timeouts
        lat = 1000;
        @(posedge clock); #1; t0 = cyc;
        startWrite(11'h060, $urandom, 4'hF); waitAw(); finishB(0);
        check("write timeout ctrlSel length", selLen, TO);
        check("write timeout BVALID cycle", bvRise - t0, 2 + TO);
        @(posedge clock); #1;
        startRead(11'h060); waitAr(); finishR(0);
        check("read timeout ctrlSel length", selLen, TO);
        lat = 0;
        @(posedge clock); #1;
        startRead(11'h060); waitAr(); finishR(0);

        // Answer in the last allowed cycle versus one cycle too late
        for (int l = TO - 1; l <= TO; l++) begin
            lat = l;
            @(posedge clock); #1;
            startWrite(11'h010 + 11'(4 * (l - TO + 1)), $urandom, 4'($urandom)); waitAw(); finishB(0);
            @(posedge clock); #1;
            startRead(11'h010 + 11'(4 * (l - TO + 1))); waitAr(); finishR(0);
        end

        // Stalled read response blocks a new write
        lat = 2;
        @(posedge clock); #1;
        startRead(11'h460); waitAr();
        for (int n = 0; n < 50 && !RVALID; n++) @(negedge clock);
        check("stall RVALID up", RVALID, 1);
        @(posedge clock); #1;
        startWrite(11'h464, $urandom, 4'h5);
        repeat (5) begin
            @(negedge clock);
            check("stall RVALID held", RVALID, 1);
            check("stall write blocked", AWREADY, 0);
        end
        finishR(0); waitAw(); finishB(0);

        // Reset in the middle of a write request
        lat = 1000;
        @(posedge clock); #1;
        startWrite(11'h0C0, 32'hA5A5A5A5, 4'hF); waitAw();
        @(negedge clock);
        check("ctrlSel before reset", ctrlSel, 1);
        #2 resetn = 1'b0;
        #1 check("outputs after async reset", {ctrlSel, BVALID, AWREADY, WREADY, ARREADY, RVALID}, 0);
        bExpQ.delete();
        @(negedge clock); #2 resetn = 1'b1;
        lat = 0;
        @(posedge clock); #1;
        startRead(11'h000); waitAr(); finishR(0);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            a = 11'($urandom_range(0, 63));
            lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 3)) : int'($urandom_range(0, TO - 1));
            stall = int'($urandom_range(0, 3));
            @(posedge clock); #1;
            if ($urandom_range(0, 1) == 1) begin
                startWrite(a, $urandom, 4'($urandom)); waitAw(); finishB(stall);
            end else begin
                startRead(a); waitAr(); finishR(stall);
            end
        end

        repeat (2) @(negedge clock);
        check("b queue drained", bExpQ.size(), 0);
        check("r queue drained", rExpQ.size(), 0);
        check("ctrl write queue drained", ctrlWQ.size(), 0);
        check("ctrl read queue drained", ctrlRQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
